fifo_4096_16i_32o: RTL and testbench
====================================

FIFO_4096_16I_32O -- requirements
Module: fifo_4096_16i_32o

Interface
REQ-001 SHALL use this reset and clock: reset tb_rst, asynchronous, active-high; clock clk. tb_rst drives both wr_rst and rd_rst; clk drives both wr_clk and rd_clk. The logic SHALL still be fully asynchronous-safe between the two domains.
REQ-002 Parameter WR_DEPTH_WIDTH, default 12, is log2 of the write depth in 16-bit words.
REQ-003 Parameter WR_DATA_WIDTH, default 16, is the write word width.
REQ-004 Parameter RD_DEPTH_WIDTH, default 11, is log2 of the read depth in 32-bit words.
REQ-005 Parameter RD_DATA_WIDTH, default 32, is the read word width.
REQ-006 Parameter ALMOST_FULL_NUM, default 4092, is the almost_full threshold in write words.
REQ-007 Parameter ALMOST_EMPTY_NUM, default 4, is the almost_empty threshold in read words.
REQ-008 wr_clk, input, 1 bit: write clock.
REQ-009 wr_rst, input, 1 bit: async active-high write-domain reset.
REQ-010 rd_clk, input, 1 bit: read clock.
REQ-011 rd_rst, input, 1 bit: async active-high read-domain reset.
REQ-012 wr_data, input, 16 bits: write word. wr_en, input, 1 bit: write request.
REQ-013 wr_full, output, 1 bit; almost_full, output, 1 bit; wr_water_level, output, 13 bits: stored 16-bit words as seen from the write domain.
REQ-014 rd_en, input, 1 bit: read request. rd_data, output, 32 bits.
REQ-015 rd_empty, output, 1 bit; almost_empty, output, 1 bit; rd_water_level, output, 12 bits: readable 32-bit words as seen from the read domain.

Function
REQ-016 Storage SHALL be 4096 x 16 bits, equivalently 2048 x 32 bits.
REQ-017 A write SHALL be accepted on a wr_clk rising edge when wr_en=1 and wr_full=0. wr_en while full SHALL be ignored, with no pointer or data change.
REQ-018 Width packing: the first-written 16-bit word of each pair SHALL appear on rd_data[15:0] and the second on rd_data[31:16].
REQ-019 A 32-bit word SHALL become readable only once both halves are written.
REQ-020 A read SHALL be accepted on a rd_clk rising edge when rd_en=1 and rd_empty=0; rd_data SHALL be valid after that same edge, giving 1-cycle latency.
REQ-021 rd_en while empty SHALL be ignored, and rd_data SHALL hold its value.
REQ-022 wr_full SHALL be registered and SHALL assert on the edge that writes the 4096th word. It SHALL deassert within 3 wr_clk cycles of a read freeing space.
REQ-023 rd_empty SHALL be registered and SHALL assert on the edge that reads the last word. It SHALL deassert within 4 rd_clk cycles after a pair completes.
REQ-024 almost_full SHALL be 1 when wr_water_level >= ALMOST_FULL_NUM.
REQ-025 almost_empty SHALL be 1 when rd_water_level <= ALMOST_EMPTY_NUM.
REQ-026 Clock-domain crossing SHALL use Gray-coded pointers, one bit wider than the address, each passed through a 2-flop synchronizer.
REQ-027 Water levels SHALL be pointer differences computed modulo 2^(depth+1). Pointer wrap-around SHALL be seamless.
REQ-028 A simultaneous read and write SHALL both be accepted when their respective flags allow.

Reset
REQ-029 While reset is high: all pointers=0, wr_full=0, almost_full=0, wr_water_level=0, rd_empty=1, almost_empty=1, rd_water_level=0, rd_data=0.
REQ-030 Reset mid-operation SHALL discard all contents, including any unpaired half-word.
REQ-031 Reset release SHALL be synchronized into each domain.

Configuration
REQ-032 Macro FIFO_4096_16I_32O_OUTPUT_REG_EN, when defined, SHALL add an output register on rd_data, making read latency 2 rd_clk cycles.
REQ-033 When FIFO_4096_16I_32O_OUTPUT_REG_EN is undefined, read latency SHALL be 1 rd_clk cycle.

Structure
REQ-034 Package fifo_4096_16i_32o_pkg SHALL hold the depth/width constants, threshold defaults, and the Gray encode/decode functions.
REQ-035 A single sub-module fifo_4096_16i_32o_ptr_sync (Gray pointer 2-flop synchronizer) SHALL be instantiated twice; the RAM SHALL be inferred.
REQ-036 The design SHALL NOT depend on GTP_GRS; the bench holds GRS_N=1.

Verification
REQ-037 After reset: rd_empty=1, almost_empty=1, wr_full=0, wr_water_level=0, rd_water_level=0.
REQ-038 Hold wr_en=1 for 4097 wr_clk edges with data 0xFFFF, 0xFFFE, ... -> 4096 accepted; wr_full=1, wr_water_level=4096, almost_full=1 from level 4092; the 4097th write is dropped.
REQ-039 Hold rd_en=1 for 2049 edges -> first rd_data=0xFFFE_FFFF; last rd_data=0xF000_F001; rd_empty=1 after the 2048th read; the 2049th read is ignored with rd_data held.
REQ-040 Write 1 word only -> rd_empty stays 1 and rd_water_level=0; the 2nd write makes rd_water_level=1 within 4 rd_clk cycles.
REQ-041 Assert reset while half full -> all flags and levels return to their reset values and subsequent reads are ignored.
REQ-042 Run simultaneous rd_en/wr_en at steady state with level 100 -> level stays constant and data order is preserved.

Source files
------------

// File: rtl/fifo_4096_16i_32o_pkg.sv
// Shared constants and Gray helpers for the 16-in / 32-out async FIFO.
// Pointers crossing domains count 32-bit words (RD_AW+1 bits).
package fifo_4096_16i_32o_pkg;

  localparam int WR_AW  = 12;
  localparam int WR_DW  = 16;
  localparam int RD_AW  = 11;
  localparam int RD_DW  = 32;
  localparam int AF_NUM = 4092;
  localparam int AE_NUM = 4;

  typedef logic [RD_AW:0] rptr_t;

  function automatic rptr_t bin2gray(rptr_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic rptr_t gray2bin(rptr_t g);
    rptr_t b;
    b = '0;
    for (int i = 0; i <= RD_AW; i++)
      b[i] = ^(g >> i);
    return b;
  endfunction

endpackage

// File: rtl/fifo_4096_16i_32o_ptr_sync.sv
// Two-flop synchronizer for a Gray-coded FIFO pointer.
// Ports: clk, rst (async high), d (other domain), q (synced).
module fifo_4096_16i_32o_ptr_sync
  import fifo_4096_16i_32o_pkg::*;
#(
  parameter int W = RD_AW + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] s1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
      q  <= '0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/fifo_4096_16i_32o.sv
// Async FIFO, 4096x16 in / 2048x32 out, first half lands in [15:0].
// Ports: wr_* (write domain), rd_* (read domain), flags, water levels.
// FIFO_4096_16I_32O_OUTPUT_REG_EN adds an rd_data register (latency 2).
module fifo_4096_16i_32o
  import fifo_4096_16i_32o_pkg::*;
#(
  parameter int WR_DEPTH_WIDTH   = WR_AW,
  parameter int WR_DATA_WIDTH    = WR_DW,
  parameter int RD_DEPTH_WIDTH   = RD_AW,
  parameter int RD_DATA_WIDTH    = RD_DW,
  parameter int ALMOST_FULL_NUM  = AF_NUM,
  parameter int ALMOST_EMPTY_NUM = AE_NUM
) (
  input  logic                     wr_clk,
  input  logic                     wr_rst,
  input  logic                     rd_clk,
  input  logic                     rd_rst,
  input  logic [WR_DATA_WIDTH-1:0] wr_data,
  input  logic                     wr_en,
  output logic                     wr_full,
  output logic                     almost_full,
  output logic [WR_DEPTH_WIDTH:0]  wr_water_level,
  input  logic                     rd_en,
  output logic [RD_DATA_WIDTH-1:0] rd_data,
  output logic                     rd_empty,
  output logic                     almost_empty,
  output logic [RD_DEPTH_WIDTH:0]  rd_water_level
);

  localparam int WA = WR_DEPTH_WIDTH;
  localparam int RA = RD_DEPTH_WIDTH;

  localparam logic [WA:0] W_FULL = {1'b1, {WA{1'b0}}};
  localparam logic [WA:0] AF_LVL = ALMOST_FULL_NUM[WA:0];
  localparam logic [RA:0] AE_LVL = ALMOST_EMPTY_NUM[RA:0];

  // Async assert, sync release, per domain.
  logic [1:0] wr_rst_q;
  logic [1:0] rd_rst_q;
  logic       wr_rs;
  logic       rd_rs;

  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) wr_rst_q <= 2'b11;
    else        wr_rst_q <= {wr_rst_q[0], 1'b0};
  end

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) rd_rst_q <= 2'b11;
    else        rd_rst_q <= {rd_rst_q[0], 1'b0};
  end

  assign wr_rs = wr_rst_q[1];
  assign rd_rs = rd_rst_q[1];

  logic [RD_DATA_WIDTH-1:0] mem [0:(1<<RA)-1];

  // Write domain: pointer counts 16-bit words.
  logic [WA:0]              wr_ptr;
  logic [WA:0]              wr_nx;
  logic [WA:0]              rd_ptr_w;
  logic [WA:0]              wr_lvl_nx;
  logic [RA:0]              wr_gray;
  logic [RA:0]              rd_gray_s;
  logic [WR_DATA_WIDTH-1:0] wr_lo;
  logic                     wr_ok;

  assign wr_ok     = wr_en & ~wr_full;
  assign wr_nx     = wr_ptr + {{WA{1'b0}}, wr_ok};
  assign rd_ptr_w  = {gray2bin(rd_gray_s), 1'b0};
  assign wr_lvl_nx = wr_nx - rd_ptr_w;

  assign wr_water_level = wr_ptr - rd_ptr_w;
  assign almost_full    = wr_water_level >= AF_LVL;

  // Only completed pairs are published, so the read side never
  // sees a half-written word.
  always_ff @(posedge wr_clk or posedge wr_rs) begin
    if (wr_rs) begin
      wr_ptr  <= '0;
      wr_gray <= '0;
      wr_full <= 1'b0;
      wr_lo   <= '0;
    end else begin
      wr_ptr  <= wr_nx;
      wr_gray <= bin2gray(wr_nx[WA:1]);
      wr_full <= wr_lvl_nx == W_FULL;
      if (wr_ok & ~wr_ptr[0]) wr_lo <= wr_data;
    end
  end

  always_ff @(posedge wr_clk) begin
    if (wr_ok & wr_ptr[0])
      mem[wr_ptr[WA-1:1]] <= {wr_data, wr_lo};
  end

  // Read domain: pointer counts 32-bit words.
  logic [RA:0]              rd_ptr;
  logic [RA:0]              rd_nx;
  logic [RA:0]              rd_gray;
  logic [RA:0]              wr_gray_s;
  logic [RA:0]              wr_ptr_r;
  logic [RD_DATA_WIDTH-1:0] ram_q;
  logic                     rd_ok;

  assign rd_ok    = rd_en & ~rd_empty;
  assign rd_nx    = rd_ptr + {{RA{1'b0}}, rd_ok};
  assign wr_ptr_r = gray2bin(wr_gray_s);

  assign rd_water_level = wr_ptr_r - rd_ptr;
  assign almost_empty   = rd_water_level <= AE_LVL;

  always_ff @(posedge rd_clk or posedge rd_rs) begin
    if (rd_rs) begin
      rd_ptr   <= '0;
      rd_gray  <= '0;
      rd_empty <= 1'b1;
      ram_q    <= '0;
    end else begin
      rd_ptr   <= rd_nx;
      rd_gray  <= bin2gray(rd_nx);
      rd_empty <= wr_ptr_r == rd_nx;
      if (rd_ok) ram_q <= mem[rd_ptr[RA-1:0]];
    end
  end

`ifdef FIFO_4096_16I_32O_OUTPUT_REG_EN
  logic [RD_DATA_WIDTH-1:0] out_q;

  always_ff @(posedge rd_clk or posedge rd_rs) begin
    if (rd_rs) out_q <= '0;
    else       out_q <= ram_q;
  end

  assign rd_data = out_q;
`else
  assign rd_data = ram_q;
`endif

  fifo_4096_16i_32o_ptr_sync #(.W(RA + 1)) u_rd2wr (
    .clk (wr_clk),
    .rst (wr_rs),
    .d   (rd_gray),
    .q   (rd_gray_s)
  );

  fifo_4096_16i_32o_ptr_sync #(.W(RA + 1)) u_wr2rd (
    .clk (rd_clk),
    .rst (rd_rs),
    .d   (wr_gray),
    .q   (wr_gray_s)
  );

endmodule

// File: tb/tb_fifo_4096_16i_32o.sv
// Bench for fifo_4096_16i_32o: directed stimulus, queue scoreboard.
// Single clk and tb_rst feed both FIFO domains.
module tb_fifo_4096_16i_32o;

  logic        clk    = 1'b0;
  logic        tb_rst = 1'b1;
  wire         grs_n  = 1'b1;
  logic [15:0] wr_data = '0;
  logic        wr_en  = 1'b0;
  logic        rd_en  = 1'b0;
  logic        wr_full, almost_full, rd_empty, almost_empty;
  logic [12:0] wr_water_level;
  logic [11:0] rd_water_level;
  logic [31:0] rd_data;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

`ifdef FIFO_4096_16I_32O_OUTPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic [1:0] acc = '0;

  always #5 clk = ~clk;

  fifo_4096_16i_32o dut (
    .wr_clk         (clk),
    .wr_rst         (tb_rst),
    .rd_clk         (clk),
    .rd_rst         (tb_rst),
    .wr_data        (wr_data),
    .wr_en          (wr_en),
    .wr_full        (wr_full),
    .almost_full    (almost_full),
    .wr_water_level (wr_water_level),
    .rd_en          (rd_en),
    .rd_data        (rd_data),
    .rd_empty       (rd_empty),
    .almost_empty   (almost_empty),
    .rd_water_level (rd_water_level)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: a read accepted at an edge shows rd_data LAT edges later.
  always @(posedge clk) begin
    if (tb_rst) acc <= '0;
    else        acc <= {acc[0], rd_en & ~rd_empty};
  end

  always @(negedge clk) begin
    if (acc[LAT-1]) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_extra: got %h want no output", rd_data);
      end else begin
        chk("rd_data", rd_data, exp_q.pop_front());
      end
    end
  end

  task automatic rst_vals(input string nm);
    chk({nm, "_full"},  32'(wr_full), 32'd0);
    chk({nm, "_af"},    32'(almost_full), 32'd0);
    chk({nm, "_wlvl"},  32'(wr_water_level), 32'd0);
    chk({nm, "_empty"}, 32'(rd_empty), 32'd1);
    chk({nm, "_ae"},    32'(almost_empty), 32'd1);
    chk({nm, "_rlvl"},  32'(rd_water_level), 32'd0);
    chk({nm, "_data"},  rd_data, 32'd0);
  endtask

  initial begin
    logic [15:0] prev;
    int n;
    int lvl;
    bit hit;
    prev = '0;

    // Reset state, then after release.
    cyc(3);
    rst_vals("in_rst");
    tb_rst = 1'b0;
    cyc(5);
    rst_vals("post_rst");

    // Fill: 4097 writes, last one dropped.
    for (int i = 0; i < 4097; i++) begin
      wr_en   = 1'b1;
      wr_data = 16'hFFFF - 16'(i);
      if (i < 4096) begin
        if (i[0]) exp_q.push_back({wr_data, prev});
        prev = wr_data;
      end
      @(negedge clk);
      n = (i < 4096) ? i + 1 : 4096;
      chk("fill_lvl",  32'(wr_water_level), 32'(n));
      chk("fill_af",   32'(almost_full), 32'(n >= 4092));
      chk("fill_full", 32'(wr_full), 32'(n == 4096));
    end
    wr_en = 1'b0;
    cyc(4);
    chk("full_rlvl",  32'(rd_water_level), 32'd2048);
    chk("full_empty", 32'(rd_empty), 32'd0);
    chk("full_ae",    32'(almost_empty), 32'd0);
    chk("full_wlvl",  32'(wr_water_level), 32'd4096);

    // Drain: 2049 reads, last one ignored.
    for (int i = 0; i < 2049; i++) begin
      rd_en = 1'b1;
      @(negedge clk);
      lvl = (i < 2048) ? 2047 - i : 0;
      chk("drain_lvl",   32'(rd_water_level), 32'(lvl));
      chk("drain_ae",    32'(almost_empty), 32'(lvl <= 4));
      chk("drain_empty", 32'(rd_empty), 32'(i >= 2047));
      if (i == LAT - 1) chk("first_word", rd_data, 32'hFFFE_FFFF);
      if (i == 3)       chk("full_clear", 32'(wr_full), 32'd0);
      if (i == 2048)    chk("held_word", rd_data, 32'hF000_F001);
    end
    rd_en = 1'b0;
    cyc(4);
    chk("last_word",  rd_data, 32'hF000_F001);
    chk("drain_wlvl", 32'(wr_water_level), 32'd0);
    chk("drain_q",    32'(exp_q.size()), 32'd0);

    // Half word stays invisible until its partner arrives.
    wr_en   = 1'b1;
    wr_data = 16'h1111;
    @(negedge clk);
    wr_en = 1'b0;
    cyc(6);
    chk("half_empty", 32'(rd_empty), 32'd1);
    chk("half_rlvl",  32'(rd_water_level), 32'd0);
    chk("half_wlvl",  32'(wr_water_level), 32'd1);
    wr_en   = 1'b1;
    wr_data = 16'h2222;
    exp_q.push_back(32'h2222_1111);
    @(negedge clk);
    wr_en = 1'b0;
    hit = 1'b0;
    for (int k = 0; k < 4 && !hit; k++) begin
      if (rd_water_level == 12'd1 && !rd_empty) hit = 1'b1;
      else @(negedge clk);
    end
    chk("pair_visible", 32'(hit), 32'd1);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    cyc(3);
    chk("pair_empty", 32'(rd_empty), 32'd1);

    // Steady state at 100 words with simultaneous traffic;
    // long enough that both pointers wrap.
    for (int i = 0; i < 200; i++) begin
      wr_en   = 1'b1;
      wr_data = 16'h1000 + 16'(i);
      if (i[0]) exp_q.push_back({wr_data, prev});
      prev = wr_data;
      @(negedge clk);
    end
    wr_en = 1'b0;
    cyc(5);
    chk("st_rlvl0", 32'(rd_water_level), 32'd100);
    chk("st_wlvl0", 32'(wr_water_level), 32'd200);
    for (int i = 0; i < 4000; i++) begin
      wr_en   = 1'b1;
      wr_data = 16'h1000 + 16'(200 + i);
      if (i[0]) exp_q.push_back({wr_data, prev});
      prev  = wr_data;
      rd_en = i[0];
      @(negedge clk);
      chk("st_range", 32'(rd_water_level >= 12'd97 &&
                          rd_water_level <= 12'd101), 32'd1);
    end
    wr_en = 1'b0;
    rd_en = 1'b0;
    cyc(5);
    chk("st_rlvl1", 32'(rd_water_level), 32'd100);
    chk("st_wlvl1", 32'(wr_water_level), 32'd200);
    rd_en = 1'b1;
    cyc(100);
    rd_en = 1'b0;
    cyc(4);
    chk("st_empty", 32'(rd_empty), 32'd1);
    chk("st_q",     32'(exp_q.size()), 32'd0);

    // Reset while half full, leaving an odd half word behind.
    for (int i = 0; i < 2049; i++) begin
      wr_en   = 1'b1;
      wr_data = 16'hA000 + 16'(i);
      @(negedge clk);
    end
    wr_en = 1'b0;
    cyc(5);
    chk("hf_rlvl", 32'(rd_water_level), 32'd1024);
    chk("hf_wlvl", 32'(wr_water_level), 32'd2049);
    tb_rst = 1'b1;
    @(negedge clk);
    rst_vals("mid_rst");
    cyc(2);
    tb_rst = 1'b0;
    cyc(5);
    rd_en = 1'b1;
    cyc(5);
    rd_en = 1'b0;
    rst_vals("after_rst");

    // The discarded half must not pair with a new write.
    wr_en   = 1'b1;
    wr_data = 16'h5555;
    @(negedge clk);
    wr_en = 1'b0;
    cyc(6);
    chk("disc_empty", 32'(rd_empty), 32'd1);
    chk("disc_rlvl",  32'(rd_water_level), 32'd0);
    wr_en   = 1'b1;
    wr_data = 16'h6666;
    exp_q.push_back(32'h6666_5555);
    @(negedge clk);
    wr_en = 1'b0;
    cyc(6);
    chk("disc_pair", 32'(rd_water_level), 32'd1);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    cyc(4);
    chk("end_q",     32'(exp_q.size()), 32'd0);
    chk("end_empty", 32'(rd_empty), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
